ddr3_app_mem_model: RTL and testbench
=====================================

// Module: ddr3_app_mem_model
// PURPOSE
//  Behavioural DDR3 MIG user-interface (app_*) slave for simulation. Sits directly downstream of the app-interface
//  traffic driver and stands in for the MIG core plus DRAM. Accepts commands and write data with configurable
//  backpressure, stores beats in an internal array and returns read data in order after a fixed latency.
// PARAMETERS
//  ADDR_W        28       app_addr width
//  DATA_W        256      beat width (one BL8 burst at 4:1)
//  MASK_W        32       DATA_W/8 byte-mask width
//  MEM_AW        10       log2 of beats stored; entry = app_addr[3 +: MEM_AW]
//  RD_LATENCY    8        cycles from read execute to app_rd_data_valid (>=1)
//  FIFO_AW       2        log2 depth of the command FIFO and the write-data FIFO
//  INIT_CYCLES   64       cycles after reset release before init_calib_complete rises
//  RDY_PATTERN   16'hFFFF app_rdy gating pattern; bit0 used, rotated right every cycle
//  WDF_PATTERN   16'hFFFF app_wdf_rdy gating pattern; same rotation rule
// PORTS
//  ui_clk              in   1       single clock; all logic on rising edge
//  ui_rst              in   1       asynchronous, active-low reset
//  app_addr            in   ADDR_W  command address; low 3 bits ignored
//  app_cmd             in   3       3'b000 write, 3'b001 read, other = protocol error, command dropped
//  app_en              in   1       command valid
//  app_rdy             out  1       command accept; transfer on app_en & app_rdy
//  app_wdf_data        in   DATA_W  write beat
//  app_wdf_mask        in   MASK_W  1 = byte NOT written
//  app_wdf_wren        in   1       write-data valid
//  app_wdf_end         in   1       last beat; must equal app_wdf_wren
//  app_wdf_rdy         out  1       write-data accept; transfer on wren & wdf_rdy
//  app_rd_data         out  DATA_W  read beat
//  app_rd_data_valid   out  1       read beat valid, single-cycle pulse per beat
//  init_calib_complete out  1       model ready
//  protocol_err        out  1       sticky error flag
// BEHAVIOUR
//  - Reset (ui_rst=0): app_rdy=0, app_wdf_rdy=0, app_rd_data=0, app_rd_data_valid=0, init_calib_complete=0,
//    protocol_err=0; both FIFOs, read pipeline, init counter and pattern registers cleared/reloaded.
//    Array contents are zero at time 0 and NOT cleared by reset. Reset mid-burst discards all in-flight reads.
//  - Init: counter counts INIT_CYCLES after reset release; init_calib_complete then stays 1 until next reset.
//  - app_rdy = init_calib_complete & !cmd_full & rdy_pat[0]; app_wdf_rdy = init_calib_complete & !wdf_full &
//    wdf_pat[0]. Both are decoded from registered state only; no combinational path from inputs.
//  - Write data may arrive before, with or after its command; beats are paired with write commands in order.
//  - Executor, at most one op per cycle, strictly in command order from the head of the command FIFO:
//    WR executes only when the write-data FIFO is non-empty: per byte, mem[idx] keeps old byte where mask=1.
//    RD executes unconditionally: mem[idx] enters a RD_LATENCY-deep shift pipeline. WR at the head blocks later RDs.
//  - Head entry is visible the cycle after acceptance, so earliest app_rd_data_valid = accept edge + 1 + RD_LATENCY.
//  - Read-after-write to same idx returns new data. Index wraps modulo 2**MEM_AW (addr 8*2**MEM_AW aliases 0).
//  - Push and pop of a full FIFO in the same cycle: not allowed, since rdy is already low while full.
//    Push and pop of a non-full FIFO in the same cycle: count unchanged.
//  - protocol_err set by: wren!=end, app_cmd not in {000,001} when accepted, or app_en/app_wdf_wren before
//    init_calib_complete. Cleared only by reset.
// STRUCTURE
//  - Package ddr3_sim_pkg: CMD_WR=3'b000, CMD_RD=3'b001, default ADDR_W/DATA_W/MASK_W.
//  - Sub-module ddr3_model_fifo: parameterised sync FIFO (WIDTH, AW) with full/empty/count.
//    Instance 1: command FIFO {cmd,idx}. Instance 2: write-data FIFO {data,mask}.
//  - Top-level holds the array, executor, read pipeline, init counter, pattern rotators and error logic.
// TESTING
//  1 Default params: 16 WR at addr 0..120 step 8, data 0..15 -> 16 RD return 0..15 in order;
//    first valid 9 cycles after first RD accept.
//  2 RDY_PATTERN=16'hAAAA, WDF_PATTERN=16'hCCCC: same traffic -> app_rdy toggles every cycle, zero data errors,
//    no beat lost or duplicated.
//  3 Write all-ones to addr 0, then mask 32'h0000_000F with data 0 -> read addr 0 returns
//    {224'h0, 32'hFFFF_FFFF}.
//  4 Write data 3 cycles before its command, then RD same addr next cycle -> read returns new data;
//    RD not executed before WR.
//  5 Write 8*1024 with data 5A -> read addr 0 returns 5A (wrap alias).
//  6 Assert ui_rst low with 4 reads in flight -> no valid after release; init_calib_complete low for 64 cycles;
//    wren=1 with end=0 -> protocol_err=1.

Source files
------------

// File: rtl/ddr3_sim_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_sim_pkg
// Shared definitions for the behavioural DDR3 MIG app-interface model:
// command encodings, default interface widths and a command legality helper.
// ---------------------------------------------------------------------------
package ddr3_sim_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_MASK_W = 32;

  // Only plain write and plain read are understood by the model.
  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/ddr3_model_fifo.sv
// ---------------------------------------------------------------------------
// ddr3_model_fifo
// Small synchronous first-word-fall-through FIFO used for the command queue
// and the write-data queue of the DDR3 app-interface model.
// Ports:
//   ui_clk, ui_rst     clock, asynchronous active-low reset
//   push, push_data    write side (ignored while full)
//   pop, pop_data      read side; pop_data shows the head entry (ignored while empty)
//   full, empty, count occupancy status, all decoded from registered state
// ---------------------------------------------------------------------------
module ddr3_model_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             ui_clk,
  input  logic             ui_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  assign push_s   = push & ~full;
  assign pop_s    = pop & ~empty;
  assign full     = (count_r == (AW+1)'(DEPTH));
  assign empty    = (count_r == {(AW+1){1'b0}});
  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge ui_clk or negedge ui_rst) begin
    if (!ui_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: an entry is only observed after it has been pushed.
  always_ff @(posedge ui_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/ddr3_app_mem_model.sv
// ---------------------------------------------------------------------------
// ddr3_app_mem_model
// Behavioural stand-in for a DDR3 MIG core plus DRAM, seen through the app_*
// user interface. Commands and write beats are queued with configurable
// backpressure, executed strictly in command order against an internal beat
// array, and read beats come back in order after a fixed latency.
// Ports:
//   ui_clk, ui_rst              clock, asynchronous active-low reset
//   app_addr/app_cmd/app_en     command channel, app_rdy = accept
//   app_wdf_data/mask/wren/end  write-data channel, app_wdf_rdy = accept
//   app_rd_data/_valid          read return, one pulse per beat
//   init_calib_complete         model ready after the init delay
//   protocol_err                sticky misuse flag
// ---------------------------------------------------------------------------
module ddr3_app_mem_model
  import ddr3_sim_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          MASK_W      = DEF_MASK_W,
  parameter int          MEM_AW      = 10,
  parameter int          RD_LATENCY  = 8,
  parameter int          FIFO_AW     = 2,
  parameter int          INIT_CYCLES = 64,
  parameter logic [15:0] RDY_PATTERN = 16'hFFFF,
  parameter logic [15:0] WDF_PATTERN = 16'hFFFF
) (
  input  logic              ui_clk,
  input  logic              ui_rst,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic [2:0]        app_cmd,
  input  logic              app_en,
  output logic              app_rdy,
  input  logic [DATA_W-1:0] app_wdf_data,
  input  logic [MASK_W-1:0] app_wdf_mask,
  input  logic              app_wdf_wren,
  input  logic              app_wdf_end,
  output logic              app_wdf_rdy,
  output logic [DATA_W-1:0] app_rd_data,
  output logic              app_rd_data_valid,
  output logic              init_calib_complete,
  output logic              protocol_err
);

  localparam int CNT_W  = $clog2(INIT_CYCLES + 1);
  localparam int CMD_FW = 1 + MEM_AW;
  localparam int WDF_FW = MASK_W + DATA_W;

  // ---------------- init counter and backpressure patterns ----------------
  logic [CNT_W-1:0] init_cnt_r;
  logic             init_done_r;
  logic [15:0]      rdy_pat_r;
  logic [15:0]      wdf_pat_r;

  // Init delay: count cycles after reset release, then latch ready until next reset.
  always_ff @(posedge ui_clk or negedge ui_rst) begin
    if (!ui_rst) begin
      init_cnt_r  <= {CNT_W{1'b0}};
      init_done_r <= 1'b0;
    end else if (!init_done_r) begin
      if (init_cnt_r == CNT_W'(INIT_CYCLES - 1)) begin
        init_done_r <= 1'b1;
      end else begin
        init_cnt_r <= init_cnt_r + CNT_W'(1'b1);
      end
    end
  end

  // Backpressure gating: bit 0 of each pattern gates its ready, rotated right every cycle.
  always_ff @(posedge ui_clk or negedge ui_rst) begin
    if (!ui_rst) begin
      rdy_pat_r <= RDY_PATTERN;
      wdf_pat_r <= WDF_PATTERN;
    end else begin
      rdy_pat_r <= {rdy_pat_r[0], rdy_pat_r[15:1]};
      wdf_pat_r <= {wdf_pat_r[0], wdf_pat_r[15:1]};
    end
  end

  // ---------------- command and write-data queues ----------------
  logic              cmd_full_s, cmd_empty_s, cmd_push_s, cmd_pop_s;
  logic [CMD_FW-1:0] cmd_head_s;
  logic              wdf_full_s, wdf_empty_s, wdf_push_s, wdf_pop_s;
  logic [WDF_FW-1:0] wdf_head_s;
  logic [FIFO_AW:0]  cmd_cnt_unused_s;
  logic [FIFO_AW:0]  wdf_cnt_unused_s;
  logic              head_is_rd_s;
  logic [MEM_AW-1:0] head_idx_s;
  logic [DATA_W-1:0] head_data_s;
  logic [MASK_W-1:0] head_mask_s;

  // Ready depends only on registered state, never on the current inputs.
  assign app_rdy     = init_done_r & ~cmd_full_s & rdy_pat_r[0];
  assign app_wdf_rdy = init_done_r & ~wdf_full_s & wdf_pat_r[0];

  // Illegal commands are handshaken but never queued.
  assign cmd_push_s = app_en & app_rdy & cmd_is_legal(app_cmd);
  assign wdf_push_s = app_wdf_wren & app_wdf_rdy;

  assign head_is_rd_s = cmd_head_s[CMD_FW-1];
  assign head_idx_s   = cmd_head_s[MEM_AW-1:0];
  assign head_mask_s  = wdf_head_s[WDF_FW-1:DATA_W];
  assign head_data_s  = wdf_head_s[DATA_W-1:0];

  ddr3_model_fifo #(.WIDTH(CMD_FW), .AW(FIFO_AW)) u_cmd_fifo (
    .ui_clk    (ui_clk),
    .ui_rst    (ui_rst),
    .push      (cmd_push_s),
    .push_data ({(app_cmd == CMD_RD), app_addr[3 +: MEM_AW]}),
    .pop       (cmd_pop_s),
    .pop_data  (cmd_head_s),
    .full      (cmd_full_s),
    .empty     (cmd_empty_s),
    .count     (cmd_cnt_unused_s)
  );

  ddr3_model_fifo #(.WIDTH(WDF_FW), .AW(FIFO_AW)) u_wdf_fifo (
    .ui_clk    (ui_clk),
    .ui_rst    (ui_rst),
    .push      (wdf_push_s),
    .push_data ({app_wdf_mask, app_wdf_data}),
    .pop       (wdf_pop_s),
    .pop_data  (wdf_head_s),
    .full      (wdf_full_s),
    .empty     (wdf_empty_s),
    .count     (wdf_cnt_unused_s)
  );

  // ---------------- executor ----------------
  logic exe_rd_s;
  logic exe_wr_s;

  // One op per cycle from the command head; a write waits for its beat and blocks everything behind it.
  always_comb begin
    exe_rd_s = 1'b0;
    exe_wr_s = 1'b0;
    if (!cmd_empty_s) begin
      if (head_is_rd_s) begin
        exe_rd_s = 1'b1;
      end else if (!wdf_empty_s) begin
        exe_wr_s = 1'b1;
      end else begin
        exe_wr_s = 1'b0;
      end
    end else begin
      exe_rd_s = 1'b0;
    end
  end

  assign cmd_pop_s = exe_rd_s | exe_wr_s;
  assign wdf_pop_s = exe_wr_s;

  // ---------------- beat array ----------------
  logic [DATA_W-1:0] mem_r [2**MEM_AW];

  // Byte-masked write; array contents survive reset.
  always_ff @(posedge ui_clk) begin
    if (exe_wr_s) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!head_mask_s[b]) begin
          mem_r[head_idx_s][8*b +: 8] <= head_data_s[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read return pipeline ----------------
  logic              pipe_vld_r  [RD_LATENCY];
  logic [DATA_W-1:0] pipe_data_r [RD_LATENCY];
  logic              rd_vld_r;
  logic [DATA_W-1:0] rd_data_r;

  // Read latency line: stage 0 captures at execute, output register adds the final cycle.
  always_ff @(posedge ui_clk or negedge ui_rst) begin
    if (!ui_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_vld_r[i]  <= 1'b0;
        pipe_data_r[i] <= {DATA_W{1'b0}};
      end
      rd_vld_r  <= 1'b0;
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      pipe_vld_r[0]  <= exe_rd_s;
      pipe_data_r[0] <= mem_r[head_idx_s];
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_r[i]  <= pipe_vld_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
      end
      rd_vld_r  <= pipe_vld_r[RD_LATENCY-1];
      rd_data_r <= pipe_data_r[RD_LATENCY-1];
    end
  end

  // ---------------- protocol error ----------------
  logic err_s;
  logic err_r;

  assign err_s = (app_wdf_wren != app_wdf_end)
               | (app_en & app_rdy & ~cmd_is_legal(app_cmd))
               | ((app_en | app_wdf_wren) & ~init_done_r);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge ui_clk or negedge ui_rst) begin
    if (!ui_rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | err_s;
    end
  end

  // Address bits outside the beat index are intentionally ignored.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{app_addr[2:0], app_addr[ADDR_W-1:3+MEM_AW],
                                cmd_cnt_unused_s, wdf_cnt_unused_s};

  assign app_rd_data         = rd_data_r;
  assign app_rd_data_valid   = rd_vld_r;
  assign init_calib_complete = init_done_r;
  assign protocol_err        = err_r;

endmodule

// File: tb/tb_ddr3_app_mem_model.sv
// ---------------------------------------------------------------------------
// tb_ddr3_app_mem_model
// Scoreboard bench: instance 0 uses default backpressure, instance 1 uses
// RDY_PATTERN=AAAA / WDF_PATTERN=CCCC. A reference beat array per instance
// predicts each read when it is accepted; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ddr3_app_mem_model;
  import ddr3_sim_pkg::*;

  logic ui_clk = 1'b0;
  logic ui_rst = 1'b0;
  always #5 ui_clk = ~ui_clk;

  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic [255:0] app_wdf_data;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  bit           sel;

  logic         rdy [2];
  logic         wrdy [2];
  logic         vld [2];
  logic         init [2];
  logic         err [2];
  logic [255:0] rdata [2];
  logic         en_g [2];
  logic         wren_g [2];
  logic         end_g [2];

  assign en_g[0]   = app_en & ~sel;
  assign en_g[1]   = app_en & sel;
  assign wren_g[0] = app_wdf_wren & ~sel;
  assign wren_g[1] = app_wdf_wren & sel;
  assign end_g[0]  = app_wdf_end & ~sel;
  assign end_g[1]  = app_wdf_end & sel;

  ddr3_app_mem_model dut_a (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(en_g[0]), .app_rdy(rdy[0]), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(wren_g[0]), .app_wdf_end(end_g[0]),
    .app_wdf_rdy(wrdy[0]), .app_rd_data(rdata[0]), .app_rd_data_valid(vld[0]),
    .init_calib_complete(init[0]), .protocol_err(err[0])
  );

  ddr3_app_mem_model #(.RDY_PATTERN(16'hAAAA), .WDF_PATTERN(16'hCCCC)) dut_b (
    .ui_clk(ui_clk), .ui_rst(ui_rst), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(en_g[1]), .app_rdy(rdy[1]), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(wren_g[1]), .app_wdf_end(end_g[1]),
    .app_wdf_rdy(wrdy[1]), .app_rd_data(rdata[1]), .app_rd_data_valid(vld[1]),
    .init_calib_complete(init[1]), .protocol_err(err[1])
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int first_acc = -1;
  logic [255:0] mm [2][1024];
  logic [255:0] exp_q [$];

  always @(posedge ui_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every returned beat is matched against the oldest prediction.
  always @(negedge ui_clk) begin
    logic [255:0] e;
    if (vld[sel] === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rd_valid: got beat %h with nothing outstanding", rdata[sel]);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", rdata[sel], e);
        if (first_acc >= 0) begin
          chk("first_rd_latency", 256'(cyc - first_acc), 256'd9);
          first_acc = -1;
        end
      end
    end
    if (vld[~sel] === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_dut_valid: got valid on unselected instance expected none");
    end
  end

  function automatic int idx_of(input logic [27:0] addr);
    return (int'(addr) / 8) % 1024;
  endfunction

  function automatic void model_wr(input int s, input logic [27:0] addr,
                                   input logic [255:0] data, input logic [31:0] mask);
    int ix;
    ix = idx_of(addr);
    for (int b = 0; b < 32; b++) begin
      if (!mask[b]) mm[s][ix][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge ui_clk);
    if (k > 0) #1;
  endtask

  task automatic do_cmd(input bit rd, input logic [27:0] addr, input bit timed);
    int n;
    bit ok;
    n = 0;
    ok = 1'b1;
    app_addr = addr;
    app_cmd  = rd ? CMD_RD : CMD_WR;
    app_en   = 1'b1;
    forever begin
      @(negedge ui_clk);
      if (rdy[sel] === 1'b1) break;
      n++;
      if (n > 300) begin
        ok = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL cmd_accept_timeout: got no app_rdy in %0d cycles expected accept", n);
        break;
      end
    end
    if (ok && rd) begin
      exp_q.push_back(mm[sel][idx_of(addr)]);
      if (timed) first_acc = cyc + 1;
    end
    @(posedge ui_clk);
    #1;
    app_en = 1'b0;
  endtask

  task automatic do_wdf(input logic [255:0] data, input logic [31:0] mask);
    int n;
    n = 0;
    app_wdf_data = data;
    app_wdf_mask = mask;
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    forever begin
      @(negedge ui_clk);
      if (wrdy[sel] === 1'b1) break;
      n++;
      if (n > 300) begin
        vectors++;
        miscompares++;
        $display("FAIL wdf_accept_timeout: got no app_wdf_rdy in %0d cycles expected accept", n);
        break;
      end
    end
    @(posedge ui_clk);
    #1;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  // lead > 0: data leads the command by lead cycles; lead < 0: data trails.
  task automatic do_write(input logic [27:0] addr, input logic [255:0] data,
                          input logic [31:0] mask, input int lead);
    fork
      begin
        if (lead < 0) wait_cyc(-lead);
        do_wdf(data, mask);
      end
      begin
        if (lead > 0) wait_cyc(lead);
        do_cmd(1'b0, addr, 1'b0);
      end
    join
    model_wr(sel, addr, data, mask);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge ui_clk);
      n++;
    end
    #1;
    chk(nm, 256'(exp_q.size()), 256'd0);
    chk({nm, "_err"}, {255'd0, err[sel]}, 256'd0);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!(init[0] === 1'b1 && init[1] === 1'b1) && n < 300) begin
      @(negedge ui_clk);
      n++;
    end
    chk("init_rise", {254'd0, init[1], init[0]}, 256'd3);
    @(posedge ui_clk);
    #1;
  endtask

  task automatic seq_traffic(input bit timed);
    for (int i = 0; i < 16; i++) do_write(28'(8 * i), 256'(i), 32'h0, 0);
    wait_cyc(5);
    for (int i = 0; i < 16; i++) do_cmd(1'b1, 28'(8 * i), timed && (i == 0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones_r, ones_w, trans;
    logic prev;
    app_addr = 28'd0; app_cmd = 3'b000; app_en = 1'b0;
    app_wdf_data = 256'd0; app_wdf_mask = 32'd0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    sel = 1'b0;
    for (int s = 0; s < 2; s++) for (int i = 0; i < 1024; i++) mm[s][i] = 256'd0;

    // reset state
    repeat (3) @(negedge ui_clk);
    chk("rst_outputs_a", {rdata[0], 5'd0}, 261'd0);
    chk("rst_flags", {248'd0, rdy[0], wrdy[0], vld[0], init[0], err[0], rdy[1], wrdy[1], vld[1]}, 256'd0);
    @(posedge ui_clk); #1;
    ui_rst = 1'b1;
    wait_init();

    // 1: sequential write/read with first-beat latency
    seq_traffic(1'b1);
    drain("t1_drain");

    // 2: patterned backpressure on instance 1
    sel = 1'b1;
    ones_r = 0; ones_w = 0; trans = 0; prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ui_clk);
      ones_r += int'(rdy[1]);
      ones_w += int'(wrdy[1]);
      if (i > 0 && rdy[1] != prev) trans++;
      prev = rdy[1];
    end
    chk("t2_rdy_ones", 256'(ones_r), 256'd4);
    chk("t2_rdy_toggles", 256'(trans), 256'd7);
    chk("t2_wdf_ones", 256'(ones_w), 256'd4);
    @(posedge ui_clk); #1;
    seq_traffic(1'b0);
    drain("t2_drain");

    // random mixed traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      for (int i = 0; i < 60; i++) begin
        logic [27:0] a;
        a = 28'($urandom_range(0, 31) * 8 + $urandom_range(0, 1) * 8192 + $urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) begin
          do_write(a, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 2) == 0) ? 32'($urandom) : 32'h0,
                   int'($urandom_range(0, 6)) - 3);
        end else begin
          do_cmd(1'b1, a, 1'b0);
        end
      end
      drain("rand_drain");
    end

    // 3: byte mask keeps old bytes
    sel = 1'b0;
    do_write(28'd0, {256{1'b1}}, 32'h0, 0);
    do_write(28'd0, 256'd0, 32'h0000_000F, 0);
    vectors++;
    if (mm[0][0] !== {224'h0, 32'hFFFF_FFFF}) begin
      miscompares++;
      $display("FAIL t3_model: got %h expected %h", mm[0][0], {224'h0, 32'hFFFF_FFFF});
    end
    do_cmd(1'b1, 28'd0, 1'b0);
    drain("t3_drain");

    // 4: data leads command by 3 cycles, read follows immediately
    do_write(28'h40, {8{32'hDEAD_BEEF}}, 32'h0, 3);
    do_cmd(1'b1, 28'h40, 1'b0);
    drain("t4_drain");

    // 5: index wrap alias
    do_write(28'd8192, 256'h5A, 32'h0, 0);
    do_cmd(1'b1, 28'd0, 1'b0);
    drain("t5_drain");

    // 6: reset with reads in flight
    for (int i = 0; i < 4; i++) do_cmd(1'b1, 28'(8 * i), 1'b0);
    wait_cyc(2);
    ui_rst = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge ui_clk);
    chk("t6_rst_state", {rdata[0], 251'd0, rdy[0], wrdy[0], vld[0], init[0], err[0]}, 512'd0);
    @(posedge ui_clk); #1;
    ui_rst = 1'b1;
    for (int i = 1; i <= 65; i++) begin
      @(negedge ui_clk);
      if (i == 64) chk("t6_init_low_64", {255'd0, init[0]}, 256'd0);
      if (i == 65) chk("t6_init_high", {255'd0, init[0]}, 256'd1);
    end
    wait_cyc(20);
    chk("t6_err_clear", {255'd0, err[0]}, 256'd0);
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b0;
    @(posedge ui_clk); #1;
    app_wdf_wren = 1'b0;
    @(negedge ui_clk);
    chk("t6_err_set", {255'd0, err[0]}, 256'd1);
    wait_cyc(5);
    chk("t6_err_sticky", {255'd0, err[0]}, 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
